// File: rtl/spmv_pkg.sv
// Shared SpMV constants: SRAM geometry, requester indices
// and the read-pipe tag carried alongside each SRAM read.
package spmv_pkg;

  localparam int SRAM_AW = 5;
  localparam int SRAM_DW = 256;
  localparam int MAX_REQ = 4;

  localparam int REQ_S0 = 0;
  localparam int REQ_S1 = 1;
  localparam int REQ_WB = 2;

  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/spmv_rr_pick.sv
// Round-robin pick: rotate req by ptr, take lowest set bit,
// rotate back. In: req_i, ptr_i. Out: one-hot gnt_o.
module spmv_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   pe;

  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N-1:0];
    pe    = rot & (~rot + N'(1));
    back  = {pe, pe} << ptr_i;
    gnt_o = back[2*N-1:N];
  end

endmodule

// File: rtl/spmv_sram_arbiter.sv
// Round-robin arbiter for one shared SRAM port with locked bursts
// and a READ_LAT read-return pipe. Ports: i_clk/i_rstn; per-requester
// i_req/i_we/i_lock/i_addr/i_wdata; o_gnt/o_rvalid/o_rdata back to
// requesters; o_sram_addr/o_sram_wr_en/o_sram_wdata/i_sram_rdata to
// the SRAM; o_busy. Define SPMV_ARB_WR_PRIORITY_EN to let any pending
// write pre-empt round-robin and locks (lowest writer index wins).
module spmv_sram_arbiter
  import spmv_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int READ_LAT = 1,
  parameter int AW       = SRAM_AW,
  parameter int DW       = SRAM_DW
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_we,
  input  logic [NUM_REQ-1:0]    i_lock,
  input  logic [NUM_REQ*AW-1:0] i_addr,
  input  logic [NUM_REQ*DW-1:0] i_wdata,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic [NUM_REQ-1:0]    o_rvalid,
  output logic [DW-1:0]         o_rdata,
  output logic [AW-1:0]         o_sram_addr,
  output logic                  o_sram_wr_en,
  output logic [DW-1:0]         o_sram_wdata,
  input  logic [DW-1:0]         i_sram_rdata,
  output logic                  o_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic               lock_vld_q, lock_vld_d;
  logic [PW-1:0]      lock_id_q, lock_id_d;
  rd_tag_t            pipe_q [READ_LAT];
  rd_tag_t            pipe_d [READ_LAT];
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] wr_req;
  logic [PW-1:0]      gidx;
  logic               any_gnt;
  logic               prio;
  logic               locked_hit;
  logic               pipe_out;
  logic               in_flight;

  spmv_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // Grant selection; the grant is masked while reset is held.
  always_comb begin
    gnt        = '0;
    prio       = 1'b0;
    wr_req     = i_req & i_we;
    locked_hit = lock_vld_q && i_req[lock_id_q];
    if (!i_rstn) begin
      gnt = '0;
    end
`ifdef SPMV_ARB_WR_PRIORITY_EN
    else if (|wr_req) begin
      gnt  = wr_req & (~wr_req + NUM_REQ'(1));
      prio = 1'b1;
    end
`endif
    else if (locked_hit) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        gnt[r] = (PW'(r) == lock_id_q);
      end
    end else begin
      gnt = rr_gnt;
    end
  end

  always_comb begin
    gidx = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) gidx = PW'(r);
    end
    any_gnt = |gnt;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt && !prio && !locked_hit) begin
      if (gidx == PW'(NUM_REQ-1)) ptr_d = '0;
      else                        ptr_d = gidx + PW'(1);
    end
  end

  // Lock drops when the owner lets go of lock or request;
  // a grant carrying i_lock (re)claims ownership.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (lock_vld_q && !(i_lock[lock_id_q] && i_req[lock_id_q])) begin
      lock_vld_d = 1'b0;
    end
    if (any_gnt && i_lock[gidx]) begin
      lock_vld_d = 1'b1;
      lock_id_d  = gidx;
    end
  end

  always_comb begin
    if (any_gnt) begin
      addr_d  = i_addr[int'(gidx)*AW +: AW];
      wdata_d = i_wdata[int'(gidx)*DW +: DW];
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end
  end

  // Tag pipe: stage 0 loads on a granted read.
  always_comb begin
    pipe_d[0]                  = '0;
    pipe_d[0].valid            = any_gnt && !i_we[gidx];
    pipe_d[0].id[NUM_REQ-1:0]  = gnt;
    for (int k = 1; k < READ_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_comb begin
    pipe_out  = pipe_q[READ_LAT-1].valid && |pipe_q[READ_LAT-1].id;
    in_flight = 1'b0;
    for (int k = 0; k < READ_LAT; k++) begin
      in_flight = in_flight | pipe_q[k].valid;
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pipe_out) begin
      rvalid_d = pipe_q[READ_LAT-1].id[NUM_REQ-1:0];
      rdata_d  = i_sram_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      for (int k = 0; k < READ_LAT; k++) pipe_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      for (int k = 0; k < READ_LAT; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign o_gnt        = gnt;
  assign o_rvalid     = rvalid_q;
  assign o_rdata      = rdata_q;
  assign o_sram_addr  = addr_d;
  assign o_sram_wdata = wdata_d;
  assign o_sram_wr_en = any_gnt && i_we[gidx];
  assign o_busy       = (|i_req) || in_flight;

endmodule

// File: tb/tb_spmv_sram_arbiter.sv
// Bench for spmv_sram_arbiter: directed scenarios plus a random
// phase, checked against a behavioural arbiter/SRAM reference.
module tb_spmv_sram_arbiter;

  localparam int N  = 3;
  localparam int L  = 1;
  localparam int AW = 5;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, sram_wdata, sram_rdata;
  logic [AW-1:0]   sram_addr;
  logic            sram_wr_en, busy;

  always #5 clk = ~clk;

  spmv_sram_arbiter #(
    .NUM_REQ (N), .READ_LAT (L), .AW (AW), .DW (DW)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req        (req),
    .i_we         (we),
    .i_lock       (lock),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_gnt        (gnt),
    .o_rvalid     (rvalid),
    .o_rdata      (rdata),
    .o_sram_addr  (sram_addr),
    .o_sram_wr_en (sram_wr_en),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata),
    .o_busy       (busy)
  );

  // SRAM environment: synchronous write, L-cycle read.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rdp [L];
  logic          ld;
  logic [AW-1:0] ld_a;
  logic [DW-1:0] ld_d;

  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    else if (sram_wr_en) mem[sram_addr] <= sram_wdata;
    rdp[0] <= mem[sram_addr];
    for (int k = 1; k < L; k++) rdp[k] <= rdp[k-1];
  end
  assign sram_rdata = rdp[L-1];

  // Reference model state
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_rd_t;

  logic [DW-1:0] ref_mem [32];
  exp_rd_t       exp_q [$];
  int            ptr, own, cyc;
  int            n_pass, n_total;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_slot(int r, bit rq, bit w, bit lk, int a,
                          logic [DW-1:0] d);
    req[r]             = rq;
    we[r]              = w;
    lock[r]            = lk;
    addr[r*AW +: AW]   = AW'(a);
    wdata[r*DW +: DW]  = d;
  endtask

  task automatic idle();
    for (int r = 0; r < N; r++) set_slot(r, 0, 0, 0, 0, '0);
  endtask

  // One clock: evaluate the reference, compare, advance.
  task automatic tick(output int g_o);
    int            g;
    bit            pr, lk;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic [DW-1:0] exp_rd;
    int            a;
    @(negedge clk);
    g  = -1;
    pr = 0;
    lk = 0;
    if (!rstn) begin
      exp_q.delete();
      ptr = 0;
      own = -1;
    end else begin
`ifdef SPMV_ARB_WR_PRIORITY_EN
      for (int r = 0; r < N; r++)
        if (g < 0 && req[r] && we[r]) begin g = r; pr = 1; end
`endif
      if (g < 0 && own >= 0 && req[own]) begin g = own; lk = 1; end
      for (int i = 0; i < N; i++)
        if (g < 0 && req[(ptr+i)%N]) g = (ptr+i)%N;
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("gnt", DW'(gnt), DW'(exp_gnt));
    chk("wr_en", DW'(sram_wr_en), DW'(g >= 0 && we[g]));
    if (g >= 0) begin
      a = int'(addr[g*AW +: AW]);
      chk("sram_addr", DW'(sram_addr), DW'(a));
      if (we[g]) chk("sram_wdata", sram_wdata, wdata[g*DW +: DW]);
    end
    if (!rstn) begin
      chk("rst_addr", DW'(sram_addr), '0);
      chk("rst_wdata", sram_wdata, '0);
      chk("rst_rdata", rdata, '0);
    end
    if (rstn && exp_q.size() == 0) chk("busy", DW'(busy), DW'(|req));
    exp_rv = '0;
    exp_rd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv[exp_q[0].id] = 1'b1;
      exp_rd = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("rvalid", DW'(rvalid), DW'(exp_rv));
    if (|exp_rv) chk("rdata", rdata, exp_rd);
    if (g >= 0) begin
      a = int'(addr[g*AW +: AW]);
      if (we[g]) ref_mem[a] = wdata[g*DW +: DW];
      else exp_q.push_back('{cyc + L + 1, g, ref_mem[a]});
      if (!pr && !lk) ptr = (g + 1) % N;
    end
    if (rstn) begin
      if (own >= 0 && !(lock[own] && req[own])) own = -1;
      if (g >= 0 && lock[g]) own = g;
    end
    g_o = g;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int            g;
    int            n0;
    bit            wpend;
    logic [DW-1:0] pat;
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    ptr     = 0;
    own     = -1;
    idle();
    ld   = 1'b0;
    ld_a = '0;
    ld_d = '0;
    rstn = 1'b0;
    #1;

    // 1: reset held with all requests high; preload memory
    for (int r = 0; r < N; r++) set_slot(r, 1, 0, 0, r, '0);
    for (int i = 0; i < 32; i++) begin
      ld         = 1'b1;
      ld_a       = AW'(i);
      ld_d       = rnd256();
      ref_mem[i] = ld_d;
      tick(g);
    end
    ld = 1'b0;
    tick(g);
    rstn = 1'b1;

    // 2: three readers, no lock, addr 1/2/3
    for (int r = 0; r < N; r++) set_slot(r, 1, 0, 0, r + 1, '0);
    tick(g);
    chk("first_gnt_req0", DW'(g), DW'(0));
    for (int i = 0; i < 3; i++) tick(g);
    idle();
    for (int i = 0; i < 3; i++) tick(g);

    // 3: req0 locked 16-read burst while req1 waits
    n0 = 0;
    set_slot(0, 1, 0, 1, 0, '0);
    tick(g);
    if (g == 0) n0++;
    for (int k = 1; k < 16; k++) begin
      set_slot(0, 1, 0, (k < 15), k, '0);
      set_slot(1, 1, 0, 0, 20, '0);
      tick(g);
      if (g == 0) n0++;
    end
    chk("burst_len", DW'(n0), DW'(16));
    set_slot(0, 0, 0, 0, 0, '0);
    tick(g);
    chk("after_burst", DW'(g), DW'(1));
    idle();
    for (int i = 0; i < 3; i++) tick(g);

    // 4: write 0xA5.. to addr 16, then read it back
    pat = {8{32'hA5A5_A5A5}};
    set_slot(2, 1, 1, 0, 16, pat);
    tick(g);
    idle();
    set_slot(0, 1, 0, 0, 16, '0);
    tick(g);
    idle();
    for (int i = 0; i < 3; i++) tick(g);
    chk("wr_readback", ref_mem[16], pat);

    // 5: reset one cycle after a read grant
    set_slot(1, 1, 0, 0, 7, '0);
    tick(g);
    idle();
    rstn = 1'b0;
    tick(g);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) tick(g);
    set_slot(0, 1, 0, 0, 3, '0);
    tick(g);
    idle();
    for (int i = 0; i < 3; i++) tick(g);

    // 6: writer arrives during a locked read burst
    wpend = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_slot(0, (k < 8), 0, (k < 7), k, '0);
      if (k == 2) wpend = 1'b1;
      set_slot(2, wpend, 1, 0, 30, rnd256());
      tick(g);
      if (g == 2) wpend = 1'b0;
    end
    idle();
    for (int i = 0; i < 3; i++) tick(g);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      for (int r = 0; r < N; r++)
        set_slot(r, $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 31),
                 rnd256());
      tick(g);
    end
    idle();
    for (int i = 0; i < 4; i++) tick(g);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
